muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide) with START/VALID handshake.
// Optional macro FAST_MUL_EN: MUL/MULH/MULHSU/MULHU complete in one cycle; divides always iterate.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic            START,
    input  logic [4:0]      ALUOP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            KILL,
    output logic            BUSY,
    output logic            VALID,
    output logic [XLEN-1:0] RESULT
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_if_wide(input logic neg, input logic [2*XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q, b_q;
    logic                neg_a_q, neg_b_q;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                busy_q, valid_q;
    logic [XLEN-1:0]     result_q;

    logic [2:0]          op_in;
    logic                sa_in, sb_in, neg_a_in, neg_b_in;
    logic [XLEN-1:0]     mag_a_in, mag_b_in;
    logic                accept, div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_res;
    logic                fast_in;
    logic [XLEN-1:0]     fast_res;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
    logic [XLEN:0]       div_rem;
    logic                div_ge;
    logic [XLEN-1:0]     div_rem_nx, quo_fix, rem_fix, calc_res;

    // Accept-time decode: signedness, magnitudes and the early-exit cases
    always_comb begin
        op_in    = ALUOP[2:0];
        sa_in    = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                   (op_in == OP_DIV) || (op_in == OP_REM);
        sb_in    = sa_in && (op_in != OP_MULHSU);
        neg_a_in = sa_in && DATA1[XLEN-1];
        neg_b_in = sb_in && DATA2[XLEN-1];
        mag_a_in = neg_if(neg_a_in, DATA1);
        mag_b_in = neg_if(neg_b_in, DATA2);
        accept   = START && !KILL && (ALUOP[4:3] == 2'b01) && (state_q != S_CALC);
        div_zero = op_in[2] && (DATA2 == '0);
        div_ovf  = op_in[2] && !op_in[0] && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = op_in[1] ? DATA1 : '1;
        else
            special_res = op_in[1] ? '0 : DATA1;
    end

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    // Sign-extend to full width; the low 2*XLEN bits of the product are exact for all variants
    assign fast_prod = {{XLEN{neg_a_in}}, DATA1} * {{XLEN{neg_b_in}}, DATA2};
    assign fast_in   = !op_in[2];
    assign fast_res  = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
    assign fast_in  = 1'b0;
    assign fast_res = '0;
`endif

    // One iteration step; acc holds {hi, lo} for multiply and {remainder, quotient} for divide
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? a_q : {XLEN{1'b0}})};
        mul_next   = {mul_sum, acc_q[XLEN-1:1]};
        div_rem    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge     = div_rem >= {1'b0, b_q};
        div_rem_nx = div_ge ? XLEN'(div_rem - {1'b0, b_q}) : div_rem[XLEN-1:0];
        div_next   = {div_rem_nx, acc_q[XLEN-2:0], div_ge};
        acc_d      = op_q[2] ? div_next : mul_next;

        prod_fix   = neg_if_wide(neg_a_q ^ neg_b_q, acc_d);
        quo_fix    = neg_if(neg_a_q ^ neg_b_q, acc_d[XLEN-1:0]);
        rem_fix    = neg_if(neg_a_q, acc_d[2*XLEN-1:XLEN]);
        case (op_q)
            OP_MUL:                      calc_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             calc_res = quo_fix;
            OP_REM, OP_REMU:             calc_res = rem_fix;
            default:                     calc_res = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (KILL) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                        result_q <= calc_res;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    if (accept) begin
                        op_q    <= op_in;
                        a_q     <= mag_a_in;
                        b_q     <= mag_b_in;
                        neg_a_q <= neg_a_in;
                        neg_b_q <= neg_b_in;
                        cnt_q   <= '0;
                        if (special) begin
                            state_q  <= S_DONE;
                            valid_q  <= 1'b1;
                            result_q <= special_res;
                        end else if (fast_in) begin
                            state_q  <= S_DONE;
                            valid_q  <= 1'b1;
                            result_q <= fast_res;
                        end else begin
                            state_q <= S_CALC;
                            busy_q  <= 1'b1;
                            acc_q   <= {{XLEN{1'b0}}, (op_in[2] ? mag_a_in : mag_b_in)};
                        end
                    end
                end
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign VALID  = valid_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit, checked against an arithmetic reference model.
// Honors FAST_MUL_EN to select the expected multiply latency.
module tb_muldiv_unit;

    logic        CLK;
    logic        RESETN;
    logic        START;
    logic [4:0]  ALUOP;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic        KILL;
    logic        BUSY;
    logic        VALID;
    logic [31:0] RESULT;

    int          n_vec;
    int          n_err;
    logic [31:0] last_exp;

    muldiv_unit dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .START  (START),
        .ALUOP  (ALUOP),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .KILL   (KILL),
        .BUSY   (BUSY),
        .VALID  (VALID),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;

    // RV32M semantics with plain 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            3'd1: begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
            3'd2: begin sp = longint'(sa) * longint'({32'b0, b}); return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return sa / sb;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return sa % sb;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) begin
`ifdef FAST_MUL_EN
            return 1;
`else
            return 33;
`endif
        end
        if (b == 0) return 1;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    // Issue one request and wait (bounded) for VALID; operands are scrambled after accept
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_n);
        res = '0;
        lat = -1;
        busy_n = 0;
        @(negedge CLK);
        START = 1'b1;
        ALUOP = op;
        DATA1 = a;
        DATA2 = b;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK);
            #1;
            if (k == 1) begin
                START = 1'b0;
                DATA1 = $urandom;
                DATA2 = $urandom;
            end
            if (BUSY) busy_n++;
            if (VALID) begin
                lat = k;
                res = RESULT;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_vec++;
        if (VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", VALID); end
        n_vec++;
        if (RESULT !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 00000000", RESULT); end
        @(negedge CLK);
        RESETN = 1'b1;
        last_exp = 32'h0;
    endtask

    task automatic run_table(input string name, input logic [4:0] ops[], input logic [31:0] as[],
                             input logic [31:0] bs[], input logic [31:0] exps[]);
        logic [31:0] res;
        int          lat;
        int          busy_n;
        int          want_lat;
        for (int i = 0; i < ops.size(); i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, busy_n);
            want_lat = exp_lat(ops[i][2:0], as[i], bs[i]);
            n_vec++;
            if (res !== exps[i]) begin
                n_err++;
                $display("FAIL %s_result[%0d]: got %h want %h", name, i, res, exps[i]);
            end
            n_vec++;
            if (lat != want_lat) begin
                n_err++;
                $display("FAIL %s_latency[%0d]: got %0d want %0d", name, i, lat, want_lat);
            end
            n_vec++;
            if (busy_n != ((want_lat == 33) ? 32 : 0)) begin
                n_err++;
                $display("FAIL %s_busy[%0d]: got %0d cycles want %0d", name, i, busy_n, (want_lat == 33) ? 32 : 0);
            end
            last_exp = exps[i];
        end
        @(posedge CLK);
        #1;
        n_vec++;
        if (VALID !== 1'b0) begin n_err++; $display("FAIL %s_pulse_width: VALID got %b want 0", name, VALID); end
    endtask

    task automatic test_multiply();
        logic [4:0]  ops[]  = '{5'b01000, 5'b01001, 5'b01011, 5'b01010};
        logic [31:0] as[]   = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs[]   = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exps[] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        run_table("mul", ops, as, bs, exps);
    endtask

    task automatic test_divide();
        logic [4:0]  ops[]  = '{5'b01100, 5'b01110, 5'b01101, 5'b01111};
        logic [31:0] as[]   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bs[]   = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exps[] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        run_table("div", ops, as, bs, exps);
    endtask

    task automatic test_special();
        logic [4:0]  ops[]  = '{5'b01101, 5'b01111, 5'b01100, 5'b01110, 5'b01100, 5'b01110};
        logic [31:0] as[]   = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'h12345, 32'h12345};
        logic [31:0] bs[]   = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] exps[] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h12345};
        run_table("special", ops, as, bs, exps);
    endtask

    task automatic test_kill();
        bit seen;
        @(negedge CLK);
        START = 1'b1; ALUOP = 5'b01101; DATA1 = 32'd1000; DATA2 = 32'd3;
        for (int k = 1; k <= 15; k++) begin
            @(posedge CLK);
            #1;
            START = 1'b0;
        end
        KILL = 1'b1;
        @(posedge CLK);
        #1;
        KILL = 1'b0;
        n_vec++;
        if (BUSY !== 1'b0 || VALID !== 1'b0) begin
            n_err++;
            $display("FAIL kill_idle: BUSY=%b VALID=%b want 0/0", BUSY, VALID);
        end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            if (VALID) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin n_err++; $display("FAIL kill_no_valid: VALID pulsed, want none"); end
        n_vec++;
        if (RESULT !== last_exp) begin n_err++; $display("FAIL kill_result_kept: got %h want %h", RESULT, last_exp); end
    endtask

    task automatic test_bad_op();
        logic [4:0] bad[] = '{5'b00000, 5'b10000, 5'b11011};
        for (int i = 0; i < bad.size(); i++) begin
            @(negedge CLK);
            START = 1'b1; ALUOP = bad[i]; DATA1 = $urandom; DATA2 = $urandom;
            for (int k = 0; k < 2; k++) begin
                @(posedge CLK);
                #1;
                n_vec++;
                if (BUSY !== 1'b0 || VALID !== 1'b0 || RESULT !== last_exp) begin
                    n_err++;
                    $display("FAIL bad_op[%0d]: BUSY=%b VALID=%b RESULT=%h want 0/0/%h", i, BUSY, VALID, RESULT, last_exp);
                end
            end
            START = 1'b0;
        end
    endtask

    task automatic test_start_held();
        logic [31:0] res;
        int          lat;
        res = '0;
        lat = -1;
        @(negedge CLK);
        START = 1'b1; ALUOP = 5'b01101; DATA1 = 32'd1000; DATA2 = 32'd7;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK);
            #1;
            if (k == 1) begin ALUOP = 5'b01000; DATA1 = $urandom; DATA2 = $urandom; end
            if (k == 32) START = 1'b0;
            if (VALID) begin lat = k; res = RESULT; break; end
        end
        START = 1'b0;
        n_vec++;
        if (res !== 32'd142) begin n_err++; $display("FAIL start_held_result: got %h want %h", res, 32'd142); end
        n_vec++;
        if (lat != 33) begin n_err++; $display("FAIL start_held_latency: got %0d want 33", lat); end
        last_exp = 32'd142;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        int          l1, l2, b1, b2;
        run_op(5'b01101, 32'd100, 32'd7, r1, l1, b1);
        run_op(5'b01111, 32'd100, 32'd7, r2, l2, b2);
        n_vec++;
        if (r1 !== 32'd14) begin n_err++; $display("FAIL b2b_first: got %h want %h", r1, 32'd14); end
        n_vec++;
        if (r2 !== 32'd2) begin n_err++; $display("FAIL b2b_second: got %h want %h", r2, 32'd2); end
        n_vec++;
        if (l2 != 33) begin n_err++; $display("FAIL b2b_latency: got %0d want 33", l2); end
        last_exp = 32'd2;
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge CLK);
        START = 1'b1; ALUOP = 5'b01101; DATA1 = 32'd1000; DATA2 = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLK);
            #1;
            START = 1'b0;
        end
        RESETN = 1'b0;
        #1;
        n_vec++;
        if (BUSY !== 1'b0 || VALID !== 1'b0 || RESULT !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid: BUSY=%b VALID=%b RESULT=%h want 0/0/0", BUSY, VALID, RESULT);
        end
        @(negedge CLK);
        RESETN = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            if (VALID) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin n_err++; $display("FAIL reset_mid_no_valid: VALID pulsed, want none"); end
        last_exp = 32'h0;
    endtask

    task automatic test_random();
        logic [31:0] res, a, b, want;
        logic [2:0]  op;
        int          lat, busy_n;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2, 3: b = $urandom_range(1, 15);
                default: ;
            endcase
            want = ref_model(op, a, b);
            run_op({2'b01, op}, a, b, res, lat, busy_n);
            n_vec++;
            if (res !== want) begin
                n_err++;
                $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, want);
            end
            n_vec++;
            if (lat != exp_lat(op, a, b)) begin
                n_err++;
                $display("FAIL random_latency[%0d] op=%0d: got %0d want %0d", i, op, lat, exp_lat(op, a, b));
            end
        end
    endtask

    initial begin
        CLK = 1'b0;
        RESETN = 1'b0;
        START = 1'b0;
        ALUOP = 5'b0;
        DATA1 = 32'h0;
        DATA2 = 32'h0;
        KILL = 1'b0;
        n_vec = 0;
        n_err = 0;
        last_exp = 32'h0;
        test_reset();
        test_multiply();
        test_kill();
        test_divide();
        test_special();
        test_bad_op();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
